// File: rtl/ram_arb_pkg.sv
// Shared types for the IF/LS RAM port arbiter: issue-FSM states and the
// identity of the requester that won the port in a given cycle.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_IF,
        RD_LS,
        WR_LS
    } issue_state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_IF,
        REQ_LS
    } requester_e;

    // What the port is doing in the cycle after this grant lands at the RAM.
    function automatic issue_state_e next_issue(requester_e who, logic ls_we);
        issue_state_e st;
        st = IDLE;
        unique case (who)
            REQ_IF:  st = RD_IF;
            REQ_LS:  st = ls_we ? WR_LS : RD_LS;
            default: st = IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Counts consecutive cycles in which IF requests but is denied. promote_o
// asserts once the count reaches StarveMax.
module ram_arb_starve_cnt #(
    parameter int unsigned StarveMax = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic if_gnt_i,
    output logic promote_o
);

    localparam int unsigned CntW = (StarveMax < 1) ? 1 : $clog2(StarveMax + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(StarveMax);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != MaxCnt) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign promote_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between IF and LS, LS first by default.
// Defining RAM_ARB_STARVE_GUARD_EN lets a starved IF win after STARVE_MAX denials.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteena,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_wren,
    input  logic [DATA_W-1:0]   ram_q
);

    logic         promote;
    requester_e   winner;
    issue_state_e state_q;
    logic         if_rvalid_q, ls_rvalid_q;

`ifdef RAM_ARB_STARVE_GUARD_EN
    ram_arb_starve_cnt #(
        .StarveMax (STARVE_MAX)
    ) u_starve_cnt (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .if_req_i  (if_req),
        .if_gnt_i  (if_gnt),
        .promote_o (promote)
    );
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign promote           = 1'b0;
`endif

    // Reset gates the grant so nothing reaches the RAM while reset_n is low.
    always_comb begin
        winner = REQ_NONE;
        if (reset_n) begin
            if (ls_req && !(promote && if_req)) begin
                winner = REQ_LS;
            end else if (if_req) begin
                winner = REQ_IF;
            end
        end
    end

    assign if_gnt = (winner == REQ_IF);
    assign ls_gnt = (winner == REQ_LS);

    always_comb begin
        ram_address = '0;
        ram_byteena = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        unique case (winner)
            REQ_IF: begin
                ram_address = if_addr;
                ram_byteena = '1;
            end
            REQ_LS: begin
                ram_address = ls_addr;
                if (ls_we) begin
                    ram_wren    = 1'b1;
                    ram_byteena = ls_be;
                    ram_data    = ls_wdata;
                end else begin
                    ram_byteena = '1;
                end
            end
            default: ;
        endcase
    end

    // Records last cycle's issue; rvalid lines up with the RAM's one-cycle read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            state_q     <= next_issue(winner, ls_we);
            if_rvalid_q <= (next_issue(winner, ls_we) == RD_IF);
            ls_rvalid_q <= (next_issue(winner, ls_we) == RD_LS);
        end
    end

    logic unused_state;
    assign unused_state = ^state_q;

    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = ram_q;
    assign ls_rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural byte-enabled RAM.
// Starvation expectations follow RAM_ARB_STARVE_GUARD_EN.
module tb_ram_port_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clock, reset_n;
    logic              if_req, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [3:0]        ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata, ls_rdata;
    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteena;
    logic [31:0]       ram_data, ram_q;
    logic              ram_wren;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_ls;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    ram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_be       (ls_be),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_gnt      (ls_gnt),
        .ls_rvalid   (ls_rvalid),
        .ls_rdata    (ls_rdata),
        .ram_address (ram_address),
        .ram_byteena (ram_byteena),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model; preload happens while reset is held.
    logic [31:0] mem [1024];
    always @(posedge clock) begin
        if (!reset_n) begin
            mem[10'h010] <= 32'hDEADBEEF;
            mem[10'h020] <= 32'hCAFEF00D;
            mem[10'h005] <= 32'h11223344;
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteena[b]) mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
        ram_q <= mem[ram_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_ls, input logic [31:0] data);
        exp_t e;
        e.is_ls = is_ls;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        if_req = 0; if_addr = '0;
        ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clock) begin
        if (if_rvalid || ls_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got if=%b ls=%b expected none at %0t",
                         if_rvalid, ls_rvalid, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rvalid_if", 32'(if_rvalid), 32'(!e.is_ls));
                chk("rvalid_ls", 32'(ls_rvalid), 32'(e.is_ls));
                chk(e.is_ls ? "ls_rdata" : "if_rdata", e.is_ls ? ls_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset_n = 0;
        repeat (3) @(posedge clock);
        #1;
        if_req = 1; ls_req = 1; ls_we = 1; ls_be = 4'hF;
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
        cyc();
        idle();
        reset_n = 1;

        // IF read.
        cyc();
        if_req = 1; if_addr = 10'h010;
        #1;
        chk("if_gnt", 32'(if_gnt), 32'd1);
        chk("if_ls_gnt", 32'(ls_gnt), 32'd0);
        chk("if_addr_pin", 32'(ram_address), 32'h010);
        chk("if_be_pin", 32'(ram_byteena), 32'hF);
        chk("if_wren_pin", 32'(ram_wren), 32'd0);
        push(0, 32'hDEADBEEF);
        cyc();
        idle();
        #1;
        chk("none_addr", 32'(ram_address), 32'd0);
        chk("none_be", 32'(ram_byteena), 32'd0);
        chk("none_data", ram_data, 32'd0);
        chk("none_wren", 32'(ram_wren), 32'd0);

        // Contention: LS wins, IF follows once LS drops.
        cyc();
        if_req = 1; if_addr = 10'h010;
        ls_req = 1; ls_we = 0; ls_addr = 10'h020;
        #1;
        chk("cont_ls_gnt", 32'(ls_gnt), 32'd1);
        chk("cont_if_gnt", 32'(if_gnt), 32'd0);
        chk("cont_addr", 32'(ram_address), 32'h020);
        push(1, 32'hCAFEF00D);
        cyc();
        ls_req = 0;
        #1;
        chk("cont2_if_gnt", 32'(if_gnt), 32'd1);
        chk("cont2_ls_gnt", 32'(ls_gnt), 32'd0);
        push(0, 32'hDEADBEEF);
        cyc();
        idle();

        // Byte write then back-to-back read of the same word.
        cyc();
        ls_req = 1; ls_we = 1; ls_be = 4'b0010; ls_addr = 10'h005; ls_wdata = 32'hAABBCCDD;
        #1;
        chk("wr_ls_gnt", 32'(ls_gnt), 32'd1);
        chk("wr_wren", 32'(ram_wren), 32'd1);
        chk("wr_be", 32'(ram_byteena), 32'h2);
        chk("wr_data", ram_data, 32'hAABBCCDD);
        chk("wr_addr", 32'(ram_address), 32'h005);
        cyc();
        ls_we = 0; ls_be = '0; ls_wdata = '0;
        #1;
        chk("rd_ls_gnt", 32'(ls_gnt), 32'd1);
        chk("rd_wren", 32'(ram_wren), 32'd0);
        chk("rd_be", 32'(ram_byteena), 32'hF);
        push(1, 32'h1122CC44);
        cyc();
        idle();

        // IF under sustained LS pressure.
        cyc();
        cyc();
        if_req = 1; if_addr = 10'h010;
        ls_req = 1; ls_we = 0; ls_addr = 10'h020;
`ifdef RAM_ARB_STARVE_GUARD_EN
        for (int i = 1; i <= 6; i++) begin
            #1;
            chk($sformatf("starve_if_gnt_%0d", i), 32'(if_gnt), 32'(i == 5));
            chk($sformatf("starve_ls_gnt_%0d", i), 32'(ls_gnt), 32'(i != 5));
            if (i == 5) push(0, 32'hDEADBEEF);
            else        push(1, 32'hCAFEF00D);
            cyc();
        end
`else
        for (int i = 1; i <= 20; i++) begin
            #1;
            chk($sformatf("starve_if_gnt_%0d", i), 32'(if_gnt), 32'd0);
            push(1, 32'hCAFEF00D);
            cyc();
        end
`endif
        idle();
        cyc();
        cyc();

        // Reset pulled in the rvalid cycle of an IF read.
        if_req = 1; if_addr = 10'h010;
        #1;
        chk("mid_if_gnt", 32'(if_gnt), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 0;
        ls_req = 1; ls_we = 1; ls_be = 4'hF;
        #1;
        chk("mid_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("mid_if_gnt0", 32'(if_gnt), 32'd0);
        chk("mid_ls_gnt0", 32'(ls_gnt), 32'd0);
        chk("mid_wren", 32'(ram_wren), 32'd0);
        cyc();
        cyc();
        chk("mid2_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("mid2_ls_rvalid", 32'(ls_rvalid), 32'd0);
        idle();
        reset_n = 1;
        cyc();
        cyc();
        chk("post_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("post_ls_rvalid", 32'(ls_rvalid), 32'd0);
        cyc();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
